// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path constants: machine word width and the default fetch queue depth.
package if_fetch_queue_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int FETCHQ_DEPTH = 4;

endpackage

// File: rtl/fetch_queue_ram.sv
// Register-array storage for the fetch queue: one synchronous write port, one
// asynchronous read port, contents cleared by the asynchronous active-low reset.
module fetch_queue_ram #(
    parameter int DEPTH       = 4,
    parameter int ENTRY_WIDTH = 64,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [ENTRY_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [ENTRY_WIDTH-1:0] rd_data
);

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_fetch_queue.sv
// In-order decoupling queue between instruction fetch and decode; a taken
// branch (flush) drops every queued wrong-path word and the word offered with it.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instruction,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instruction,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 push;
    logic                 pop;
    logic [2*WIDTH-1:0]   rd_entry;

    // Ready/valid depend only on registered count, so fetch Freeze never
    // sees a combinational path from decode stalls or the branch flush.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    fetch_queue_ram #(
        .DEPTH       (DEPTH),
        .ENTRY_WIDTH (2 * WIDTH),
        .ADDR_WIDTH  (PTR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({in_pc, in_instruction}),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    assign out_pc          = rd_entry[2*WIDTH-1:WIDTH];
    assign out_instruction = rd_entry[WIDTH-1:0];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the fetch buffer.
module tb_if_fetch_queue;

    import if_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_pc = '0;
    logic [WIDTH-1:0]  in_instruction = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_pc;
    logic [WIDTH-1:0]  out_instruction;
    logic              out_ready = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [2*WIDTH-1:0] model_q [$];

    if_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_ready        (in_ready),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_ready       (out_ready),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_model();
        check("count", WIDTH'(count), WIDTH'(model_q.size()));
        check("out_valid", WIDTH'(out_valid), WIDTH'(model_q.size() != 0));
        check("in_ready", WIDTH'(in_ready), WIDTH'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            check("out_pc", out_pc, model_q[0][2*WIDTH-1:WIDTH]);
            check("out_instruction", out_instruction, model_q[0][WIDTH-1:0]);
        end
    endtask

    // Apply one cycle of inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input logic v, input logic [WIDTH-1:0] pc,
                        input logic [WIDTH-1:0] ins, input logic ordy, input logic fl);
        bit accept;
        bit consume;
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins;
        out_ready      = ordy;
        flush          = fl;
        accept  = v && (model_q.size() != DEPTH) && !fl;
        consume = (model_q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (!rst) begin
            model_q.delete();
        end else if (fl) begin
            model_q.delete();
        end else begin
            if (consume) void'(model_q.pop_front());
            if (accept) model_q.push_back({pc, ins});
        end
        #1;
        check_model();
    endtask

    initial begin
        // Reset held with fetch presenting a word.
        rst = 1'b0;
        step(1'b1, 32'd9, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b1, 32'd9, 32'h1234_5678, 1'b0, 1'b0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instruction, 32'd0);
        check("rst_count", WIDTH'(count), 32'd0);
        check("rst_in_ready", WIDTH'(in_ready), 32'd1);

        // First push appears the cycle after acceptance.
        rst = 1'b1;
        step(1'b1, 32'd1, 32'hE3A0_0001, 1'b0, 1'b0);
        check("first_out_valid", WIDTH'(out_valid), 32'd1);
        check("first_out_pc", out_pc, 32'd1);
        check("first_out_instr", out_instruction, 32'hE3A0_0001);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Fill with decode stalled; pc 5 is held by the frozen fetch stage.
        for (int p = 1; p <= 4; p++) step(1'b1, WIDTH'(p), WIDTH'(32'hA000 + p), 1'b0, 1'b0);
        check("fill_count", WIDTH'(count), 32'd4);
        check("fill_in_ready", WIDTH'(in_ready), 32'd0);
        step(1'b1, 32'd5, 32'hA005, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, 32'd5, 32'hA005, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Streaming with pointer wrap.
        for (int p = 1; p <= 20; p++) step(1'b1, WIDTH'(p), WIDTH'(32'hB000 + p), 1'b1, 1'b0);
        check("stream_count", WIDTH'(count), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush mid-queue drops the queued words and the word offered with it.
        for (int p = 7; p <= 9; p++) step(1'b1, WIDTH'(p), WIDTH'(32'hC000 + p), 1'b0, 1'b0);
        step(1'b1, 32'd10, 32'hC00A, 1'b0, 1'b1);
        check("flush_out_valid", WIDTH'(out_valid), 32'd0);
        step(1'b1, 32'h40, 32'hC040, 1'b0, 1'b0);
        check("flush_new_head", out_pc, 32'h40);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h77, 32'h77, 1'b0, 1'b1);

        // Push and pop offered together at full, then refill.
        for (int p = 1; p <= 4; p++) step(1'b1, WIDTH'(32'h100 + p), WIDTH'(32'hD000 + p), 1'b0, 1'b0);
        step(1'b1, 32'h105, 32'hD005, 1'b1, 1'b0);
        check("full_pop_count", WIDTH'(count), 32'd3);
        step(1'b1, 32'h105, 32'hD005, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 32'h200, 32'hE000, 1'b0, 1'b0);
        step(1'b1, 32'h201, 32'hE001, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_q.delete();
        check("async_count", WIDTH'(count), 32'd0);
        check("async_out_valid", WIDTH'(out_valid), 32'd0);
        check("async_out_pc", out_pc, 32'd0);
        rst = 1'b1;

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Decoupling buffer between the instruction fetch stage and the decode stage. Each cycle the fetch stage is not frozen, the block captures its next-PC value and instruction word into a small in-order queue. It presents the oldest entry to decode and backpressures fetch through `in_ready`, which drives the fetch stage's `Freeze` input as `~in_ready`. A taken branch flushes every queued wrong-path entry.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; must be a power of two, ≥2.
- `WIDTH`, default `WORD_WIDTH` (32): width of both the PC and instruction fields.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low; asserting it low clears all state immediately.
- `in_valid`  in  1: fetch stage presents a word this cycle.
- `in_pc`  in  WIDTH: fetch stage next-PC value (address of the fetched instruction + 1; PC is word-addressed).
- `in_instruction`  in  WIDTH: fetched instruction word.
- `in_ready`  out  1: queue can accept; fetch Freeze = ~in_ready.
- `flush`  in  1: Branch_Taken from execute; discard all entries.
- `out_valid`  out  1: head entry valid.
- `out_pc`  out  WIDTH: head entry PC field.
- `out_instruction`  out  WIDTH: head entry instruction field.
- `out_ready`  in  1: decode consumes the head entry this cycle (low on hazard stall).
- `count`  out  clog2(DEPTH)+1: number of occupied entries.

## Operation
- State: storage array of DEPTH entries, each holding {pc, instruction}; `wr_ptr` and `rd_ptr` of clog2(DEPTH) bits each; `count`.
- Pointers wrap modulo DEPTH naturally. `count` alone distinguishes full from empty.
- `in_ready` = (count != DEPTH). It is a function of registered state only, with no combinational path from `out_ready` or `flush`.
- push = in_valid & in_ready & ~flush. On push, write the entry at wr_ptr and increment wr_ptr.
- pop = out_valid & out_ready & ~flush. On pop, increment rd_ptr.
- Count update:
  - push & pop: count unchanged. This is legal when full, because the pop frees the slot only for the next cycle; push is already blocked by in_ready.
  - push only: count + 1.
  - pop only: count − 1.
- Flush dominates everything:
  - count ← 0 and rd_ptr ← wr_ptr.
  - The word presented in the flush cycle is discarded.
  - Storage contents are left as-is.
- `out_valid` = (count != 0).
- `out_pc` and `out_instruction` read the entry at rd_ptr. Their value when out_valid = 0 is not checked, except at reset.
- Illegal states (count > DEPTH) are unreachable. No error output is provided.

## Timing
- Reset (rst low, asynchronous): count = 0, wr_ptr = rd_ptr = 0, and all storage entries = 0. Resulting outputs: out_valid = 0, out_pc = 0, out_instruction = 0, in_ready = 1. Reset takes effect mid-operation regardless of any push, pop or flush in progress.
- Latency: a word pushed at edge N appears on out_* with out_valid = 1 from edge N onward, i.e. it is usable in the cycle after acceptance. There is no same-cycle bypass, even when the queue is empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full: in_ready drops in the cycle after the DEPTH-th push. It rises in the cycle after the first pop from full.
- Flush: in the cycle after a flush edge, out_valid = 0 and in_ready = 1. The fetch stage's branch-target word, presented in that cycle, is accepted normally.
- Flush while empty: no effect beyond discarding a simultaneous in_valid.

## Structure
- `WORD_WIDTH` comes from the shared `constants.h`. Add a `FETCHQ_DEPTH` default of 4 there.
- One sub-module, `fetch_queue_ram`:
  - DEPTH × (2·WIDTH) register array with asynchronous active-low clear.
  - One synchronous write port and one asynchronous read port.
- Pointer, count and flush control stay in `if_fetch_queue`.

## Test plan
- Reset: hold rst = 0 with in_valid = 1 → out_valid = 0, in_ready = 1, count = 0, out_pc = 0. Release, push pc = 1 / instr = 0xE3A00001 → next cycle out_valid = 1, out_pc = 1, out_instruction = 0xE3A00001.
- Fill: out_ready = 0, push pcs 1..5 → after 4 pushes count = 4 and in_ready = 0. pc 5 is held by the frozen fetch stage and not lost. Raise out_ready → out_pc sequence 1, 2, 3, 4, then 5 after re-acceptance.
- Streaming: in_valid = out_ready = 1 for 20 cycles, pcs 1..20 → count stays at 1, output is in order with no gaps, and the pointers wrap cleanly.
- Flush mid-queue: count = 3 (pcs 7, 8, 9), assert flush with in_valid = 1 and pc = 10 → next cycle count = 0, out_valid = 0. A subsequent push of pc = 0x40 becomes the head.
- Simultaneous push and pop at full: count = 4 with out_ready = 1 → count = 3 the next cycle, then refills. No entry is duplicated or dropped.
- Asynchronous reset mid-stream: drop rst between edges with count = 2 → count, out_valid and out_pc are 0 immediately, before the next edge.
